vga_timing_param: RTL
=====================

# vga_timing_param

Parametrised VGA timing generator: the successor to the fixed 800x600 `vga_timing`. It produces horizontal and vertical counters, sync pulses and blanking flags for any mode described by porch/sync/active parameters. It adds selectable sync polarity, a pixel clock-enable, a synchronous restart, and frame/line start strobes. It sits at the head of the video pipeline; the top level packs its outputs into `vga_if` for downstream draw stages.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch, cycles
- `H_SYNC`, 128, horizontal sync width, cycles
- `H_BP`, 88, horizontal back porch, cycles
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch, lines
- `V_SYNC`, 4, vertical sync width, lines
- `V_BP`, 23, vertical back porch, lines
- `HS_POL`, 1, hsync active level (1 = active-high)
- `VS_POL`, 1, vsync active level
- `CNT_W`, 11, counter width
- `clk`  in  1  pixel-domain clock
- `rst`  in  1  asynchronous, active-high reset
- `ce`  in  1  pixel advance enable; outputs hold when low
- `restart`  in  1  synchronous restart to (0,0)
- `hcount`  out  CNT_W  horizontal position
- `vcount`  out  CNT_W  vertical position
- `hsync`, `vsync`  out  1  sync, polarity per `HS_POL`/`VS_POL`
- `hblnk`, `vblnk`  out  1  blanking flags, active-high
- `line_start`  out  1  one-cycle strobe at hcount=0
- `frame_start`  out  1  one-cycle strobe at (0,0)
- `frame_cnt`  out  16  frame counter (only with `VGA_TIMING_FRAME_CNT_EN`)

## Operation
- Derived constants: `HTOT = H_ACTIVE+H_FP+H_SYNC+H_BP`, `HSYNC_START = H_ACTIVE+H_FP`, `HSYNC_STOP = HSYNC_START+H_SYNC-1`, `HBLK_START = H_ACTIVE`, `HBLK_STOP = HTOT-1`. Vertical constants are derived the same way.
- Elaboration `$error` if any parameter is 0 or if `HTOT`/`VTOT` > 2**CNT_W.
- With `ce` high, hcount increments and wraps `HTOT-1` -> 0. On that wrap, vcount increments and wraps `VTOT-1` -> 0.
- All outputs are registered and consistent with the counts they are presented with:
  - hsync active iff hcount ∈ [HSYNC_START, HSYNC_STOP].
  - hblnk iff hcount ∈ [HBLK_START, HBLK_STOP].
  - vsync/vblnk are defined likewise on vcount.
- `line_start` is high iff the presented hcount is 0 and was entered by a `ce` advance or a restart. `frame_start` additionally requires vcount 0.
- `restart` takes priority over `ce`. The next cycle presents (0,0) with sync inactive, blanks 0, and `line_start` and `frame_start` both 1.
- The state machine is the counter pair itself; there are no other states.

## Timing
- Reset values: hcount 0, vcount 0, hsync `~HS_POL`, vsync `~VS_POL`, hblnk 0, vblnk 0, line_start 0, frame_start 0, frame_cnt 0.
- Latency is one cycle from a `ce`-qualified edge to the updated outputs.
- With `ce` low: counters, sync and blank outputs hold. Strobes are 0 and never repeat while held.
- Default mode: hcount=839 -> hsync=1 the next cycle; hcount=967 -> hsync=0 the next cycle. hcount=799 -> hblnk=1; hcount=1055 -> hblnk=0.
- At hcount=1055 and vcount=627, the next cycle shows vcount=0, hcount=0 and frame_start=1.
- Vertical edges change only on the hcount `HTOT-1` -> 0 wrap.
- Reset asserted mid-frame forces the reset values immediately (asynchronous). Counting resumes on the first `ce` edge after release. The first strobe after reset is the first `line_start` at the next line wrap.
- `restart` and `ce` asserted together: restart wins.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: the `frame_cnt` port exists. It increments, wrapping at 2**16, in the same cycle `frame_start` is presented, including strobes caused by restart. Reset clears it to 0.
- `VGA_TIMING_FRAME_CNT_EN` undefined: the `frame_cnt` port and its register are absent. All other behaviour is identical.

## Test plan
- Default parameters, `ce`=1, reset for 2 cycles, run 2 frames. Required response:
  - hcount ≤ 1055 and vcount ≤ 627 throughout.
  - All sync/blank edge assertions above hold.
  - frame_start strobes exactly 1056*628 cycles apart.
- `HS_POL`=0, `VS_POL`=0 -> the reset level of both syncs is 1. hsync=0 exactly for hcount 840..967; vsync=0 exactly for vcount 601..604.
- 640x480 mode (H 640/16/96/48, V 480/10/2/33), `CNT_W`=10 -> hcount wraps 799->0, vcount wraps 524->0, hsync active for hcount 656..751.
- `ce` toggling 1,0 (divide-by-2) -> each count value persists exactly 2 cycles. Strobes last 1 cycle.
- Assert `restart` at hcount=300, vcount=200 -> the next cycle shows (0,0), frame_start=1, syncs inactive. With the macro defined, frame_cnt increments by 1.
- Assert `rst` asynchronously mid-line, between clock edges -> outputs take reset values before the next edge. Resume from (0,0) after release.

Source files
------------

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA timing generator with sync polarity, pixel ce, restart and strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_param #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             restart,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOT - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] HB_START = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VB_START = CNT_W'(V_ACTIVE);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CNT_W == 0 ||
        HTOT > 2**CNT_W || VTOT > 2**CNT_W) begin : g_bad_param
        $error("vga_timing_param: zero timing parameter or total exceeds counter range");
    end

    logic [CNT_W-1:0] hcount_d, hcount_q, vcount_d, vcount_q;
    logic hsync_d, hsync_q, vsync_d, vsync_q, hblnk_d, hblnk_q, vblnk_d, vblnk_q;
    logic line_start_d, line_start_q, frame_start_d, frame_start_q;

    // Every registered output is decoded from the next counts, so it always matches the counts it is presented with.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (restart) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (ce) begin
            hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + CNT_W'(1);
            vcount_d = (hcount_q != H_LAST) ? vcount_q :
                       (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);
        end
        line_start_d  = (restart || ce) && hcount_d == '0;
        frame_start_d = line_start_d && vcount_d == '0;
        hsync_d = (hcount_d >= HS_START && hcount_d <= HS_STOP) ? HS_POL : ~HS_POL;
        vsync_d = (vcount_d >= VS_START && vcount_d <= VS_STOP) ? VS_POL : ~VS_POL;
        hblnk_d = hcount_d >= HB_START && hcount_d <= H_LAST;
        vblnk_d = vcount_d >= VB_START && vcount_d <= V_LAST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_d, frame_cnt_q;

    always_comb frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif
endmodule
